mdu: RTL and testbench

Iterative multiply/divide unit sitting directly downstream of the general register file: it consumes the two register read buses (busA, busB) for MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the architectural HI/LO registers that MFHI/MFLO read back. Operands are captured on a start pulse, and the operation runs for a fixed number of cycles while Busy is high. The controller uses Busy to stall any later MDU instruction.

---
 rtl/mdu.sv | 198 +++++++++++++++++++
 tb/tb_mdu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module      : mdu
//  Description : Iterative multiply/divide unit holding the HI/LO registers.
//                MULT/MULTU use a shift-add loop and DIV/DIVU a restoring
//                divide loop, both on operand magnitudes and both WIDTH
//                cycles long. One final cycle applies sign correction and
//                writes HI/LO. MTHI/MTLO write HI/LO directly while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;

    // Combinational helpers for the datapath.
    logic             start_ok;
    logic             in_signed;
    logic [WIDTH-1:0] in_abs_a, in_abs_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [2*WIDTH-1:0] prod;

    // Requests are only honoured while idle; a busy unit drops them entirely.
    assign start_ok  = Start && (state_q == S_IDLE);
    // MULT (0) and DIV (2) are the signed operations.
    assign in_signed = ~Op[0];
    assign in_abs_a  = (in_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign in_abs_b  = (in_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
    // Magnitudes of the captured operands used by every iteration.
    assign mag_a     = neg_a_q ? (~a_q + 1'b1) : a_q;
    assign mag_b     = neg_b_q ? (~b_q + 1'b1) : b_q;

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic: IDLE -> RUN for WIDTH cycles -> FIX -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok && !Op[2]) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_LAST) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand capture, one iteration per RUN cycle, final write in FIX.
    always_comb begin
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_a} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        prod      = {acc_hi_q, acc_lo_q};
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    if (!Op[2]) begin
                        is_div_d = Op[1];
                        neg_a_d  = in_signed & A[WIDTH-1];
                        neg_b_d  = in_signed & B[WIDTH-1];
                        a_d      = A;
                        b_d      = B;
                        cnt_d    = '0;
                        acc_hi_d = '0;
                        // Multiply shifts the multiplier (B) out of the low half;
                        // divide shifts the dividend (A) out of the low half.
                        acc_lo_d = Op[1] ? in_abs_a : in_abs_b;
                    end else if (Op == OP_MTHI) begin
                        hi_d = A;
                    end else if (Op == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            S_RUN: begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                if (is_div_q) begin
                    // Restoring step: the partial remainder is always below the
                    // divisor, so the shifted value fits in WIDTH+1 bits.
                    if (div_shift >= {1'b0, mag_b}) begin
                        acc_hi_d = WIDTH'(div_shift - {1'b0, mag_b});
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    if (b_q == '0) begin
                        // Divide by zero leaves the dividend in HI, all ones in LO.
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        // Quotient truncates toward zero; remainder follows dividend.
                        lo_d = (neg_a_q ^ neg_b_q) ? (~acc_lo_q + 1'b1) : acc_lo_q;
                        hi_d = neg_a_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
                    end
                end else begin
                    if (neg_a_q ^ neg_b_q) begin
                        prod = ~prod + 1'b1;
                    end
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Output decode: Busy is registered from the next state, so Start never
    // reaches it combinationally.
    always_comb begin
        busy_d = (state_d != S_IDLE);
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu
//  Description : Scoreboard bench for mdu. The driver pushes expected HI/LO
//                results computed with plain integer arithmetic; a monitor
//                pops and compares whenever Busy falls.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_q[$];
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    bit          abort_pending = 0;

    mdu #(.WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    endtask

    // Reference model: architectural result {HI, LO} from integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa, sb, q, r;
        logic [63:0] res;
        sa  = a;
        sb  = b;
        res = '0;
        case (op)
            3'd0: begin
                sp  = longint'(sa) * longint'(sb);
                res = sp;
            end
            3'd1: begin
                up  = 64'(a) * 64'(b);
                res = up;
            end
            3'd2: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r, q};
                end
            end
            3'd3: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = {exp_hi, exp_lo};
        endcase
        return res;
    endfunction

    // Drive one request; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_done);
        logic [63:0] r;
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b;
        if (!Busy) begin
            if (op <= 3'd3) begin
                r = model(op, a, b);
                if (expect_done) exp_q.push_back(r);
                exp_hi = r[63:32];
                exp_lo = r[31:0];
            end else if (op == 3'd4) exp_hi = a;
            else if (op == 3'd5) exp_lo = a;
        end
        @(negedge Clk);
        Start = 1'b0; Op = 3'($urandom); A = $urandom; B = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            $display("FAIL wait_idle: Busy still 1 after %0d cycles, expected 0", n);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            4: return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: on every completion pop the oldest expectation and compare.
    initial begin : monitor
        logic [63:0] e;
        bit busy_prev = 0;
        int busy_cnt  = 0;
        forever begin
            @(negedge Clk);
            if (Busy) begin
                busy_cnt = busy_prev ? busy_cnt + 1 : 1;
            end else if (busy_prev) begin
                if (abort_pending) begin
                    abort_pending = 0;
                end else if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: completion with empty scoreboard, HI=0x%08h LO=0x%08h", HI, LO);
                end else begin
                    e = exp_q.pop_front();
                    check("result_hi", HI, e[63:32]);
                    check("result_lo", LO, e[31:0]);
                    check("busy_cycles", busy_cnt, LAT);
                end
            end
            busy_prev = Busy;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [2:0] op;
        Reset = 1'b0; Start = 1'b0; Op = '0; A = '0; B = '0;
        repeat (3) @(negedge Clk);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_hi", HI, 32'h0);
        check("reset_lo", LO, 32'h0);
        Reset = 1'b1;
        @(negedge Clk);

        // Directed cases.
        issue(3'd0, 32'hFFFF_FFFD, 32'd5, 1);           wait_idle();
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);   wait_idle();
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1);           wait_idle();
        issue(3'd3, 32'd100, 32'd7, 1);                 wait_idle();
        issue(3'd3, 32'h1234_5678, 32'h0, 1);           wait_idle();
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);   wait_idle();
        issue(3'd2, 32'hDEAD_BEEF, 32'h0, 1);           wait_idle();

        // MTHI: visible the next cycle, never busy.
        issue(3'd4, 32'hAAAA_5555, 32'h0, 0);
        check("mthi_hi", HI, 32'hAAAA_5555);
        check("mthi_busy", 32'(Busy), 32'd0);
        issue(3'd5, 32'h0BAD_F00D, 32'h0, 0);
        check("mtlo_lo", LO, 32'h0BAD_F00D);
        // Reserved opcodes change nothing.
        issue(3'd6, 32'h1111_1111, 32'h0, 0);
        issue(3'd7, 32'h2222_2222, 32'h0, 0);
        check("rsvd_busy", 32'(Busy), 32'd0);
        check("rsvd_hi", HI, 32'hAAAA_5555);
        check("rsvd_lo", LO, 32'h0BAD_F00D);

        // MULT 3x4 with a dropped MTLO mid-run; HI/LO hold until the final write.
        issue(3'd0, 32'd3, 32'd4, 1);
        repeat (5) @(negedge Clk);
        issue(3'd5, 32'd1, 32'h0, 0);
        check("midrun_hold_hi", HI, 32'hAAAA_5555);
        check("midrun_hold_lo", LO, 32'h0BAD_F00D);
        wait_idle();
        @(negedge Clk);
        check("after_mtlo_drop_lo", LO, 32'd12);

        // Randomized, issued back-to-back right after Busy falls.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 3));
            issue(op, rand_operand(), rand_operand(), 1);
            wait_idle();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
        end

        // Abort a MULT with reset around cycle 10.
        issue(3'd0, 32'd1234, 32'd5678, 0);
        repeat (8) @(negedge Clk);
        abort_pending = 1;
        #2 Reset = 1'b0;
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_hi", HI, 32'h0);
        check("abort_lo", LO, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (40) @(negedge Clk);
        check("post_abort_busy", 32'(Busy), 32'd0);
        check("post_abort_hi", HI, 32'h0);
        check("post_abort_lo", LO, 32'h0);

        // One more operation after reset to confirm clean restart.
        issue(3'd1, 32'd6, 32'd7, 1);
        wait_idle();
        repeat (3) @(negedge Clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
